// File: rtl/llsc_link_monitor_pkg.sv
// Shared types and helpers for the LL/SC link monitor.
// LLSC_TIMEOUT_EN (optional define) enables per-channel reservation lifetime counters.
package llsc_link_monitor_pkg;

    typedef enum logic {
        LINK_IDLE   = 1'b0,
        LINK_LINKED = 1'b1
    } link_state_e;

    // Channel-index width; a single-channel build still carries a 1-bit select.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Any channel code at or above the channel count denotes an external master.
    function automatic logic is_ext_master(input int unsigned ch, input int unsigned num_ch);
        return (ch >= num_ch);
    endfunction

endpackage

// File: rtl/llsc_link_monitor_entry.sv
// One channel's reservation: link flag, granule address, match compares.
// With LLSC_TIMEOUT_EN defined it also ages the link and drops it after TIMEOUT_CYC-1 cycles.
module llsc_link_entry
    import llsc_link_monitor_pkg::*;
#(
    parameter int GW          = 30,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          Rst_n,
    input  logic          flush,
    input  logic          ll_req,
    input  logic [GW-1:0] ll_gran,
    input  logic          clr,
    input  logic [GW-1:0] sc_gran,
    input  logic [GW-1:0] st_gran,
    output logic          linked,
    output logic          sc_match,
    output logic          st_match,
    output logic          expire
);

    link_state_e   state_reg;
    logic [GW-1:0] gran_reg;

    assign linked   = (state_reg == LINK_LINKED);
    assign sc_match = linked && (gran_reg == sc_gran);
    assign st_match = linked && (gran_reg == st_gran);

`ifdef LLSC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_reg;

    assign expire = linked && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_reg <= '0;
        end else if (flush || expire || ll_req) begin
            cnt_reg <= '0;
        end else if (linked) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYC;

    assign expire = 1'b0;
`endif

    // Expiry outranks a new LL; an LL outranks every remote clear.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= LINK_IDLE;
            gran_reg  <= '0;
        end else if (flush || expire) begin
            state_reg <= LINK_IDLE;
        end else if (ll_req) begin
            state_reg <= LINK_LINKED;
            gran_reg  <= ll_gran;
        end else if (clr) begin
            state_reg <= LINK_IDLE;
        end
    end

endmodule

// File: rtl/llsc_link_monitor.sv
// Per-thread LL/SC reservation tracker: SC pass/fail resolution and clear fan-out.
// LLSC_TIMEOUT_EN (optional define) bounds each reservation to TIMEOUT_CYC cycles.
module llsc_link_monitor
    import llsc_link_monitor_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int ADDR_W      = 32,
    parameter  int GRAN_LSB    = 2,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int CH_W        = ch_idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     Rst_n,
    input  logic [NUM_CH-1:0]        flush,
    input  logic [NUM_CH-1:0]        ll_req,
    input  logic [NUM_CH*ADDR_W-1:0] ll_addr,
    input  logic                     sc_req,
    input  logic [CH_W-1:0]          sc_ch,
    input  logic [ADDR_W-1:0]        sc_addr,
    input  logic                     st_valid,
    input  logic [CH_W-1:0]          st_ch,
    input  logic [ADDR_W-1:0]        st_addr,
    output logic                     sc_done_o,
    output logic                     sc_pass_o,
    output logic [NUM_CH-1:0]        LLbit_o
);

    localparam int GW = ADDR_W - GRAN_LSB;

    logic [NUM_CH-1:0] linked;
    logic [NUM_CH-1:0] sc_match;
    logic [NUM_CH-1:0] st_match;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] st_hit;
    logic [NUM_CH-1:0] clr;
    logic [GW-1:0]     sc_gran;
    logic [GW-1:0]     st_gran;
    logic [CH_W-1:0]   sc_sel;
    logic              sc_ch_ok;
    logic              st_ext;
    logic              sc_pass_now;
    logic              sc_done_reg;
    logic              sc_pass_reg;

    assign sc_gran = sc_addr[ADDR_W-1:GRAN_LSB];
    assign st_gran = st_addr[ADDR_W-1:GRAN_LSB];
    assign st_ext  = is_ext_master(32'(st_ch), NUM_CH);

    if (NUM_CH == 1) begin : g_single
        logic unused_sc_ch;
        assign unused_sc_ch = ^sc_ch;
        assign sc_sel       = '0;
        assign sc_ch_ok     = 1'b1;
    end else begin : g_multi
        assign sc_sel   = sc_ch;
        assign sc_ch_ok = !is_ext_master(32'(sc_ch), NUM_CH);
    end

    if (GRAN_LSB > 0) begin : g_low_bits
        logic unused_low;
        assign unused_low = ^{sc_addr[GRAN_LSB-1:0], st_addr[GRAN_LSB-1:0]};
    end

    // The SC sees pre-edge state; any same-cycle loss of its link makes it fail.
    always_comb begin
        sc_pass_now = 1'b0;
        if (sc_req && sc_ch_ok) begin
            sc_pass_now = sc_match[sc_sel] && !flush[sc_sel] && !expire[sc_sel] && !st_hit[sc_sel];
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic st_own;

        assign st_own     = !st_ext && (st_ch == CH_W'(gi));
        assign st_hit[gi] = st_valid && !st_own && st_match[gi];
        assign clr[gi]    = (sc_req && sc_ch_ok && (sc_sel == CH_W'(gi)))
                          || (sc_pass_now && (sc_sel != CH_W'(gi)) && sc_match[gi])
                          || st_hit[gi];

        if (GRAN_LSB > 0) begin : g_ll_low
            logic unused_ll_low;
            assign unused_ll_low = ^ll_addr[gi*ADDR_W +: GRAN_LSB];
        end

        llsc_link_entry #(
            .GW          (GW),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_entry (
            .clk      (clk),
            .Rst_n    (Rst_n),
            .flush    (flush[gi]),
            .ll_req   (ll_req[gi]),
            .ll_gran  (ll_addr[gi*ADDR_W+GRAN_LSB +: GW]),
            .clr      (clr[gi]),
            .sc_gran  (sc_gran),
            .st_gran  (st_gran),
            .linked   (linked[gi]),
            .sc_match (sc_match[gi]),
            .st_match (st_match[gi]),
            .expire   (expire[gi])
        );
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sc_done_reg <= 1'b0;
            sc_pass_reg <= 1'b0;
        end else begin
            sc_done_reg <= sc_req;
            if (sc_req) begin
                sc_pass_reg <= sc_pass_now;
            end
        end
    end

    assign sc_done_o = sc_done_reg;
    assign sc_pass_o = sc_pass_reg;
    assign LLbit_o   = linked;

endmodule
